// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - shared compare unit behind a NUM_REQ-way valid/ready arbiter (COMPARE_ARB_RR_EN selects round-robin)

// Single-cycle comparator: EQ, NE, signed LT/GE, unsigned LTU/GEU; any other encoding gives 0.
module compare_unit (
  input  logic [2:0]  op_i,
  input  logic [31:0] in1_i,
  input  logic [31:0] in2_i,
  output logic        res_o
);

  localparam logic [2:0] OP_EQ  = 3'd0;
  localparam logic [2:0] OP_NE  = 3'd1;
  localparam logic [2:0] OP_LT  = 3'd2;
  localparam logic [2:0] OP_GE  = 3'd3;
  localparam logic [2:0] OP_LTU = 3'd4;
  localparam logic [2:0] OP_GEU = 3'd5;

  // Decode the operation and evaluate it on the full 32-bit operands.
  always_comb begin
    res_o = 1'b0;
    case (op_i)
      OP_EQ:   res_o = (in1_i == in2_i);
      OP_NE:   res_o = (in1_i != in2_i);
      OP_LT:   res_o = ($signed(in1_i) <  $signed(in2_i));
      OP_GE:   res_o = ($signed(in1_i) >= $signed(in2_i));
      OP_LTU:  res_o = (in1_i <  in2_i);
      OP_GEU:  res_o = (in1_i >= in2_i);
      default: res_o = 1'b0;
    endcase
  end

endmodule

module compare_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*3-1:0]  req_op_i,
  input  logic [NUM_REQ*32-1:0] req_in1_i,
  input  logic [NUM_REQ*32-1:0] req_in2_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [NUM_REQ-1:0]    rsp_res_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Stage A: one registered request (or empty).
  logic              a_valid;
  logic [2:0]        a_op;
  logic [31:0]       a_in1;
  logic [31:0]       a_in2;
  logic [IDX_W-1:0]  a_idx;

  logic [NUM_REQ-1:0] in_flight;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic               cmp_res;

  logic [2:0]  op_arr  [NUM_REQ];
  logic [31:0] in1_arr [NUM_REQ];
  logic [31:0] in2_arr [NUM_REQ];

  // Split the flattened request buses into per-requester fields.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      op_arr[k]  = req_op_i[k*3 +: 3];
      in1_arr[k] = req_in1_i[k*32 +: 32];
      in2_arr[k] = req_in2_i[k*32 +: 32];
    end
  end

  // A requester may be granted only when it has nothing in stage A and no pending response.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      in_flight[k] = a_valid && (a_idx == IDX_W'(k));
    end
    eligible = req_valid_i & ~in_flight & ~rsp_valid_o;
  end

`ifdef COMPARE_ARB_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   rr_sum;
  logic [IDX_W-1:0] rr_cand;

  // Round-robin pick: the first eligible requester at or after the pointer wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    rr_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      rr_cand = rr_sum[IDX_W-1:0];
      if (!gnt_any && eligible[rr_cand]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_cand;
      end
    end
  end

  // The pointer moves past the winner only when a request is actually accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end
`else
  logic [IDX_W-1:0] fp_cand;

  // Fixed priority pick: the lowest eligible index wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    fp_cand = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      fp_cand = IDX_W'(i);
      if (!gnt_any && eligible[fp_cand]) begin
        gnt_any = 1'b1;
        gnt_idx = fp_cand;
      end
    end
  end
`endif

  // One-hot grant; ready is forced low while reset is held so nothing looks accepted.
  always_comb begin
    grant = '0;
    if (gnt_any) begin
      grant[gnt_idx] = 1'b1;
    end
    req_ready_o = grant & {NUM_REQ{rst_n_i}};
  end

  // Stage A: capture the winning request's op, operands and index.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      a_valid <= 1'b0;
      a_op    <= '0;
      a_in1   <= '0;
      a_in2   <= '0;
      a_idx   <= '0;
    end else begin
      a_valid <= gnt_any;
      if (gnt_any) begin
        a_op  <= op_arr[gnt_idx];
        a_in1 <= in1_arr[gnt_idx];
        a_in2 <= in2_arr[gnt_idx];
        a_idx <= gnt_idx;
      end
    end
  end

  compare_unit u_compare_unit (
    .op_i  (a_op),
    .in1_i (a_in1),
    .in2_i (a_in2),
    .res_o (cmp_res)
  );

  // Stage B: write the result into its requester's slot; the slot clears only when consumed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_valid_o <= '0;
      rsp_res_o   <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (a_valid && (a_idx == IDX_W'(k))) begin
          rsp_valid_o[k] <= 1'b1;
          rsp_res_o[k]   <= cmp_res;
        end else if (rsp_valid_o[k] && rsp_ready_i[k]) begin
          rsp_valid_o[k] <= 1'b0;
        end
      end
    end
  end

endmodule
